// File: rtl/shifter_pkg.sv
// Shared types and defaults for the registered barrel shifter.
// Optional rotate support is controlled by SHIFTER_ROTATE_EN.
package shifter_pkg;

   typedef enum logic [1:0] {
      SH_SLL  = 2'b00,
      SH_SRL  = 2'b01,
      SH_SRA  = 2'b10,
      SH_ROTR = 2'b11
   } shift_op_e;

   localparam int SHIFTER_WIDTH = 32;

endpackage

// File: rtl/shifter_barrel.sv
// Combinational log-stage barrel shifter: stage k shifts by 2**k when shamt[k] is set.
// SHIFTER_ROTATE_EN builds the rotate fill path; otherwise op 11 shifts left like SLL.
module shifter_barrel
   import shifter_pkg::*;
#(
   parameter int WIDTH = SHIFTER_WIDTH,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] din,
   input  logic [SHW-1:0]   shamt,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] res
);

   shift_op_e        w_op;
   logic             w_left;
   logic             w_sign;
   logic [WIDTH-1:0] w_stage [SHW+1];

   assign w_op = shift_op_e'(op);

   always_comb begin
      w_left = (w_op == SH_SLL);
`ifndef SHIFTER_ROTATE_EN
      if (w_op == SH_ROTR) begin
         w_left = 1'b1;
      end
`endif
   end

   // Every right stage fills from the original sign bit, so SRA stays exact across stages.
   assign w_sign     = (w_op == SH_SRA) & din[WIDTH-1];
   assign w_stage[0] = din;

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      localparam int N = 1 << k;
      logic [WIDTH-1:0] w_shifted;

      always_comb begin
         if (w_left) begin
            w_shifted = {w_stage[k][WIDTH-N-1:0], {N{1'b0}}};
`ifdef SHIFTER_ROTATE_EN
         end else if (w_op == SH_ROTR) begin
            w_shifted = {w_stage[k][N-1:0], w_stage[k][WIDTH-1:N]};
`endif
         end else begin
            w_shifted = {{N{w_sign}}, w_stage[k][WIDTH-1:N]};
         end
      end

      assign w_stage[k+1] = shamt[k] ? w_shifted : w_stage[k];
   end

   assign res = w_stage[SHW];

endmodule

// File: rtl/shifter.sv
// Registered barrel shifter: one-cycle latency, valid flag and zero flag.
// Rotate (op 11) is available only when SHIFTER_ROTATE_EN is defined.
module shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = SHIFTER_WIDTH,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic [SHW-1:0]   shamt,
   input  logic [1:0]       op,
   input  logic             in_valid,
   output logic [WIDTH-1:0] dout,
   output logic             out_valid,
   output logic             zero
);

   logic [WIDTH-1:0] w_res;
   logic [WIDTH-1:0] r_dout;
   logic             r_valid;
   logic             r_zero;

   shifter_barrel #(.WIDTH(WIDTH)) u_barrel (
      .din   (din),
      .shamt (shamt),
      .op    (op),
      .res   (w_res)
   );

   // Result and zero flag hold while idle; only the valid flag tracks in_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout  <= '0;
         r_valid <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_dout <= w_res;
            r_zero <= (w_res == '0);
         end
      end
   end

   assign dout      = r_dout;
   assign out_valid = r_valid;
   assign zero      = r_zero;

endmodule

// File: tb/tb_shifter.sv
// Scoreboard bench for shifter: driver pushes expected results, monitor pops on out_valid.
// Expected rotate behaviour follows SHIFTER_ROTATE_EN.
module tb_shifter;

   logic        clk;
   logic        rst;
   logic [31:0] din;
   logic [4:0]  shamt;
   logic [1:0]  op;
   logic        in_valid;
   logic [31:0] dout;
   logic        out_valid;
   logic        zero;

   int unsigned n_cmp;
   int unsigned n_err;
   logic [32:0] sb_q[$];
   logic [31:0] last_exp;

   shifter #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .shamt     (shamt),
      .op        (op),
      .in_valid  (in_valid),
      .dout      (dout),
      .out_valid (out_valid),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                         input logic [1:0] o);
      logic [63:0] dd;
      case (o)
         2'b00: return d << s;
         2'b01: return d >> s;
         2'b10: return 32'($signed(d) >>> s);
         default: begin
`ifdef SHIFTER_ROTATE_EN
            dd = {d, d} >> s;
            return dd[31:0];
`else
            dd = '0;
            return d << s;
`endif
         end
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present one input for one edge; expectation is queued only if it will be captured.
   task automatic drive(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o,
                        input logic v);
      logic [31:0] e;
      din = d; shamt = s; op = o; in_valid = v;
      if (v && !rst) begin
         e = model(d, s, o);
         sb_q.push_back({(e == 32'h0), e});
         last_exp = e;
      end
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      logic [32:0] e;
      if (out_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: got out_valid with dout %h, expected no output", dout);
         end else begin
            e = sb_q.pop_front();
            check("sb_dout", dout, e[31:0]);
            check("sb_zero", {31'h0, zero}, {31'h0, e[32]});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1);
   end

   initial begin
      n_cmp = 0; n_err = 0; last_exp = '0;
      rst = 1'b1; din = 32'hFFFFFFF8; shamt = 5'd2; op = 2'b00; in_valid = 1'b1;

      for (int i = 0; i < 2; i++) begin
         drive(32'hFFFFFFF8, 5'd2, 2'b00, 1'b1);
         check("rst_dout", dout, 32'h0);
         check("rst_valid", {31'h0, out_valid}, 32'h0);
         check("rst_zero", {31'h0, zero}, 32'h0);
      end
      rst = 1'b0;

      drive(32'hFFFFFFF8, 5'd2, 2'b00, 1'b1);
      check("branch_valid", {31'h0, out_valid}, 32'h1);
      check("branch_dout", dout, 32'hFFFFFFE0);
      drive(32'h00000008, 5'd2, 2'b00, 1'b1);
      drive(32'hFFFFFFF8, 5'd2, 2'b01, 1'b1);
      drive(32'hFFFFFFF8, 5'd2, 2'b10, 1'b1);
      drive(32'hFFFFFFF8, 5'd2, 2'b11, 1'b1);
      drive(32'h80000000, 5'd31, 2'b10, 1'b1);
      for (int o = 0; o < 4; o++) drive(32'hA5A5A5A5, 5'd0, 2'(o), 1'b1);
      drive(32'h00000001, 5'd31, 2'b00, 1'b1);
      drive(32'h80000000, 5'd1, 2'b00, 1'b1);
      check("sll_out_zero", {31'h0, zero}, 32'h1);
      drive(32'h00000001, 5'd1, 2'b11, 1'b1);
`ifdef SHIFTER_ROTATE_EN
      check("rotr_dir", dout, 32'h80000000);
`else
      check("rotr_dir", dout, 32'h00000002);
`endif

      drive(32'h12345678, 5'd4, 2'b01, 1'b1);
      drive(32'h87654321, 5'd8, 2'b10, 1'b1);
      drive(32'h0F0F0F0F, 5'd3, 2'b00, 1'b1);
      drive(32'hDEADBEEF, 5'd7, 2'b00, 1'b0);
      check("drop_valid", {31'h0, out_valid}, 32'h0);
      check("drop_hold", dout, last_exp);

      drive(32'hCAFEF00D, 5'd5, 2'b01, 1'b1);
      rst = 1'b1;
      drive(32'h13579BDF, 5'd9, 2'b10, 1'b1);
      check("midrst_dout", dout, 32'h0);
      check("midrst_valid", {31'h0, out_valid}, 32'h0);
      rst = 1'b0;
      drive(32'h0000F000, 5'd12, 2'b01, 1'b1);
      check("post_rst_dout", dout, 32'h0000000F);

      for (int i = 0; i < 300; i++) begin
         drive($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) != 0));
      end
      drive(32'h0, 5'd0, 2'b00, 1'b0);

      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending results, expected 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
